scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, number of scan cells in the controlled chain (legal 1..64).
REQ-002 SHALL have parameter CAP_CYCLES, default 1, number of functional capture cycles (legal 1..4).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one shift-in/capture/shift-out sequence.
REQ-006 SHALL have port abort  input  1  terminate the current sequence.
REQ-007 SHALL have port pattern_in  input  CHAIN_LEN  stimulus to load into the chain.
REQ-008 SHALL have port scan_out  input  1  Q of the chain tail cell.
REQ-009 SHALL have port scan_en  output  1  drives SE of every chain cell (1 = shift, 0 = functional capture).
REQ-010 SHALL have port scan_in  output  1  drives SI of the chain head cell.
REQ-011 SHALL have port busy  output  1  sequence in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port response_out  output  CHAIN_LEN  captured chain contents, valid from done onward.

Function
REQ-014 SHALL implement states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
REQ-015 In IDLE, start=1 SHALL latch pattern_in and transition to SHIFT_IN; start is ignored in every other state.
REQ-016 SHIFT_IN SHALL last exactly CHAIN_LEN cycles with scan_en=1; cycle k (0-based) drives scan_in = pattern_in[CHAIN_LEN-1-k].
REQ-017 CAPTURE SHALL last exactly CAP_CYCLES cycles with scan_en=0 and scan_in=0.
REQ-018 SHIFT_OUT SHALL last exactly CHAIN_LEN cycles with scan_en=1 and scan_in=0; scan_out sampled in cycle k is stored at response_out[CHAIN_LEN-1-k].
REQ-019 DONE SHALL last one cycle with done=1 and scan_en=0, then return to IDLE.
REQ-020 With start sampled at edge 0, done SHALL be high in the cycle after edge 2*CHAIN_LEN+CAP_CYCLES+1 (CHAIN_LEN=16, CAP_CYCLES=1: cycle 34).
REQ-021 busy SHALL be 1 in all states except IDLE.
REQ-022 The cycle counter SHALL be $clog2(CHAIN_LEN+1) bits wide, cleared on every state entry, and never wrap.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with scan_en=0; done SHALL not pulse and response_out SHALL keep its previous value.
REQ-024 abort together with start in IDLE SHALL leave the block in IDLE; abort takes priority.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset=1 SHALL force IDLE and set scan_en=0, scan_in=0, busy=0, done=0, response_out=0, and counter=0; it overrides start and abort.
REQ-027 reset asserted mid-sequence SHALL discard the sequence without a done pulse.

Configuration
REQ-028 Macro SCAN_CTRL_COMPARE_EN defined SHALL add input expected [CHAIN_LEN-1:0] (latched with pattern_in) and output pass (1 bit, registered, updated with done, 1 iff response equals expected, reset 0).
REQ-029 Without SCAN_CTRL_COMPARE_EN, neither port nor comparison logic SHALL exist.

Structure
REQ-030 Package scan_ctrl_pkg SHALL hold the state enum typedef and the default CHAIN_LEN/CAP_CYCLES constants.
REQ-031 Pattern and response shift registers SHALL be one sub-module scan_ctrl_shreg (parallel load, serial shift, parallel read), instantiated twice.

Verification
REQ-032 Bench chain: CHAIN_LEN=16 scan cells, SD tied to 16'h1234; pattern_in=16'hA5C3, start -> chain holds 16'hA5C3 after SHIFT_IN, done in cycle 34, response_out=16'h1234.
REQ-033 start re-pulsed at cycles 5 and 20 of a sequence -> ignored, done still in cycle 34, exactly one done pulse.
REQ-034 abort at cycle 10 -> scan_en=0 and busy=0 next cycle, no done, response_out unchanged.
REQ-035 reset at cycle 20 -> all outputs at reset values the next cycle; a new start then completes normally.
REQ-036 SCAN_CTRL_COMPARE_EN with expected=16'h1234 -> pass=1; with expected=16'h1235 -> pass=0.
REQ-037 CHAIN_LEN=1, CAP_CYCLES=4, SD=1, pattern_in=0 -> done in cycle 7, response_out=1.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and default sizing for the scan chain controller.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    localparam int DEF_CHAIN_LEN  = 16;
    localparam int DEF_CAP_CYCLES = 1;

endpackage

// File: rtl/scan_ctrl_shreg.sv
// Parallel-load, serial-shift (toward the MSB), parallel-read register.
module scan_ctrl_shreg #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_shift;

    if (WIDTH == 1) begin : g_narrow
        assign q_shift = sin;
    end else begin : g_wide
        assign q_shift = {q[WIDTH-2:0], sin};
    end

    always_ff @(posedge clock) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= q_shift;
    end

endmodule

// File: rtl/scan_ctrl.sv
// Scan chain sequencer: shift pattern in, capture, shift response out.
// Optional response compare is enabled by defining SCAN_CTRL_COMPARE_EN.
//
// state     | meaning
// IDLE      | waiting for start
// SHIFT_IN  | serialising the latched pattern into the chain head
// CAPTURE   | functional clocks with scan_en low
// SHIFT_OUT | collecting the chain tail into the response register
// DONE      | one-cycle completion, then back to IDLE
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int CAP_CYCLES = DEF_CAP_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern_in,
`ifdef SCAN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] expected,
    output logic                 pass,
`endif
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response_out
);

    // Counter must also cover the capture window when the chain is very short.
    localparam int CW_CHAIN = $clog2(CHAIN_LEN + 1);
    localparam int CW_CAP   = $clog2(CAP_CYCLES + 1);
    localparam int CW       = (CW_CHAIN > CW_CAP) ? CW_CHAIN : CW_CAP;
    localparam logic [CW-1:0] N_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CAP_CYCLES - 1);

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   load_pat;
    logic                   se_nxt, si_nxt, busy_nxt, done_nxt, smp_nxt, last_nxt;
    logic                   smp_q, last_q;
    logic [CHAIN_LEN-1:0]   pat_q, resp_q, resp_final;
    logic                   unused_bits;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        load_pat  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start && !abort) begin
                    state_nxt = SHIFT_IN;
                    load_pat  = 1'b1;
                end
            end
            SHIFT_IN: begin
                if (cnt == N_LAST) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = '0;
                end
            end
            CAPTURE: begin
                if (cnt == C_LAST) begin
                    state_nxt = SHIFT_OUT;
                    cnt_nxt   = '0;
                end
            end
            SHIFT_OUT: begin
                if (cnt == N_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    // Outputs are a registered decode of the current state, so they trail it by one cycle.
    always_comb begin
        se_nxt   = (state == SHIFT_IN) || (state == SHIFT_OUT);
        si_nxt   = (state == SHIFT_IN) && pat_q[CHAIN_LEN-1];
        busy_nxt = (state != IDLE);
        done_nxt = (state == DONE);
        smp_nxt  = (state == SHIFT_OUT);
        last_nxt = (state == SHIFT_OUT) && (cnt == N_LAST);
        if (abort) begin
            se_nxt   = 1'b0;
            si_nxt   = 1'b0;
            busy_nxt = 1'b0;
            done_nxt = 1'b0;
            smp_nxt  = 1'b0;
            last_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_en      <= 1'b0;
            scan_in      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            smp_q        <= 1'b0;
            last_q       <= 1'b0;
            response_out <= '0;
        end else begin
            scan_en <= se_nxt;
            scan_in <= si_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            smp_q   <= smp_nxt;
            last_q  <= last_nxt;
            if (last_q && !abort)
                response_out <= resp_final;
        end
    end

    scan_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_pat (
        .clock (clock),
        .reset (reset),
        .load  (load_pat),
        .shift (state == SHIFT_IN),
        .din   (pattern_in),
        .sin   (1'b0),
        .q     (pat_q)
    );

    scan_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_resp (
        .clock (clock),
        .reset (reset),
        .load  (1'b0),
        .shift (smp_q),
        .din   ('0),
        .sin   (scan_out),
        .q     (resp_q)
    );

    // The last tail bit is folded in directly so response_out lands together with done.
    if (CHAIN_LEN == 1) begin : g_resp_one
        assign resp_final = scan_out;
    end else begin : g_resp_many
        assign resp_final = {resp_q[CHAIN_LEN-2:0], scan_out};
    end

    assign unused_bits = ^{pat_q, resp_q[CHAIN_LEN-1]};

`ifdef SCAN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            exp_q <= '0;
            pass  <= 1'b0;
        end else begin
            if (load_pat)
                exp_q <= expected;
            if (last_q && !abort)
                pass <= (resp_final == exp_q);
        end
    end
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Randomised scoreboard bench for scan_ctrl with behavioural scan chains.
module tb_scan_ctrl;

    localparam int N   = 16;
    localparam int C   = 1;
    localparam int TOT = 2 * N + C + 1;

    logic         clock = 1'b0;
    logic         reset, start, abort;
    logic [N-1:0] pattern_in, response_out;
    logic         scan_out, scan_en, scan_in, busy, done;

    logic         start1;
    logic         abort1 = 1'b0;
    logic [0:0]   pattern1, response1;
    logic         scan_out1, scan_en1, scan_in1, busy1, done1;

`ifdef SCAN_CTRL_COMPARE_EN
    logic [N-1:0] expected;
    logic         pass;
    logic [0:0]   expected1;
    logic         pass1;
`endif

    logic [N-1:0] chain = '0;
    logic [N-1:0] sd = 16'h1234;
    logic         chain1 = 1'b0;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int trk_E = -1;
    logic [N-1:0] trk_pat = '0;
    logic [N-1:0] model_resp = '0;
    logic         model_pass = 1'b0;

    typedef struct {
        int           cyc;
        logic [N-1:0] resp;
        logic         pas;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   mon_t;

    scan_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(C)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .pattern_in   (pattern_in),
`ifdef SCAN_CTRL_COMPARE_EN
        .expected     (expected),
        .pass         (pass),
`endif
        .scan_out     (scan_out),
        .scan_en      (scan_en),
        .scan_in      (scan_in),
        .busy         (busy),
        .done         (done),
        .response_out (response_out)
    );

    scan_ctrl #(.CHAIN_LEN(1), .CAP_CYCLES(4)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .start        (start1),
        .abort        (abort1),
        .pattern_in   (pattern1),
`ifdef SCAN_CTRL_COMPARE_EN
        .expected     (expected1),
        .pass         (pass1),
`endif
        .scan_out     (scan_out1),
        .scan_en      (scan_en1),
        .scan_in      (scan_in1),
        .busy         (busy1),
        .done         (done1),
        .response_out (response1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edges <= edges + 1;

    // Chain cells: SE=1 shifts SI toward the tail, SE=0 captures SD.
    always @(posedge clock) chain  <= scan_en  ? {chain[N-2:0], scan_in} : sd;
    always @(posedge clock) chain1 <= scan_en1 ? scan_in1 : 1'b1;
    assign scan_out  = chain[N-1];
    assign scan_out1 = chain1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: actual=1 required=0 at edge %0d", edges);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", 32'(edges), 32'(mon_e.cyc));
                check("response_out", 32'(response_out), 32'(mon_e.resp));
`ifdef SCAN_CTRL_COMPARE_EN
                check("pass", 32'(pass), 32'(mon_e.pas));
`endif
            end
        end
        if (trk_E >= 0) begin
            mon_t = edges - trk_E;
            if (mon_t >= 1 && mon_t <= TOT) begin
                check("scan_en", 32'(scan_en),
                      32'((mon_t <= N) || (mon_t >= N + C + 1 && mon_t <= 2 * N + C)));
                check("scan_in", 32'(scan_in), 32'((mon_t <= N) ? trk_pat[N - mon_t] : 1'b0));
                check("busy", 32'(busy), 32'(1));
                if (mon_t == N + 1)
                    check("chain_loaded", 32'(chain), 32'(trk_pat));
            end
        end
    end

    task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] sdv, input logic [N-1:0] expv,
                           input int sp0, input int sp1, input int ab, input int rs);
        int   e0;
        logic cut;
        cut        = 1'b0;
        pattern_in = pat;
        sd         = sdv;
`ifdef SCAN_CTRL_COMPARE_EN
        expected   = expv;
`endif
        start = 1'b1;
        @(posedge clock); #1;
        e0      = edges;
        start   = 1'b0;
        trk_pat = pat;
        trk_E   = e0;
        sb.push_back('{e0 + TOT, sdv, (sdv == expv)});
        for (int t = 1; t <= TOT + 3 && !cut; t++) begin
            start = (t == sp0) || (t == sp1);
            abort = (t == ab);
            reset = (t == rs);
            @(posedge clock); #1;
            start = 1'b0;
            if (abort || reset) begin
                trk_E = -1;
                sb.delete(sb.size() - 1);
                check("cut_scan_en", 32'(scan_en), 32'(0));
                check("cut_busy", 32'(busy), 32'(0));
                check("cut_done", 32'(done), 32'(0));
                if (reset) begin
                    model_resp = '0;
                    model_pass = 1'b0;
                    check("rst_scan_in", 32'(scan_in), 32'(0));
                    check("rst_response", 32'(response_out), 32'(0));
`ifdef SCAN_CTRL_COMPARE_EN
                    check("rst_pass", 32'(pass), 32'(0));
`endif
                end
                abort = 1'b0;
                reset = 1'b0;
                cut   = 1'b1;
            end
        end
        trk_E = -1;
        if (cut) begin
            repeat (TOT + 3) @(posedge clock);
            #1;
            check("cut_keeps_response", 32'(response_out), 32'(model_resp));
`ifdef SCAN_CTRL_COMPARE_EN
            check("cut_keeps_pass", 32'(pass), 32'(model_pass));
`endif
        end else begin
            model_resp = sdv;
            model_pass = (sdv == expv);
        end
    endtask

    initial begin
        int           e1;
        logic         got;
        logic [N-1:0] r_pat, r_sd, r_exp;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start1     = 1'b0;
        pattern_in = '0;
        pattern1   = 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
        expected   = '0;
        expected1  = 1'b1;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_scan_en", 32'(scan_en), 32'(0));
        check("reset_scan_in", 32'(scan_in), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_response", 32'(response_out), 32'(0));
        check("reset_response_len1", 32'(response1), 32'(0));
`ifdef SCAN_CTRL_COMPARE_EN
        check("reset_pass", 32'(pass), 32'(0));
`endif
        reset = 1'b0;
        @(posedge clock); #1;

        run_seq(16'hA5C3, 16'h1234, 16'h1234, 5, 20, 0, 0);
        run_seq(16'hA5C3, 16'h1234, 16'h1235, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            r_pat = N'($urandom);
            r_sd  = N'($urandom);
            r_exp = ($urandom_range(1, 0) == 1) ? r_sd : (r_sd ^ (N'(1) << $urandom_range(N - 1, 0)));
            run_seq(r_pat, r_sd, r_exp, $urandom_range(TOT - 1, 1), $urandom_range(TOT - 1, 1), 0, 0);
        end

        run_seq(16'hA5C3, 16'h0F0F, 16'h0F0F, 0, 0, 10, 0);
        run_seq(N'($urandom), 16'h7E81, 16'h7E81, 0, 0, TOT, 0);
        run_seq(N'($urandom), N'($urandom), 16'h0000, 0, 0, $urandom_range(TOT, 1), 0);
        run_seq(16'hA5C3, 16'h1234, 16'h1234, 0, 0, 0, 20);
        run_seq(16'hA5C3, 16'h1234, 16'h1234, 0, 0, 0, 0);

        start1 = 1'b1;
        @(posedge clock); #1;
        e1     = edges;
        start1 = 1'b0;
        got    = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (done1) begin
                got = 1'b1;
                check("len1_done_cycle", 32'(edges), 32'(e1 + 7));
                check("len1_response", 32'(response1), 32'(1));
`ifdef SCAN_CTRL_COMPARE_EN
                check("len1_pass", 32'(pass1), 32'(1));
`endif
            end
        end
        check("len1_done_seen", 32'(got), 32'(1));

        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
